// File: rtl/clusterv_tile_sram_banked.sv
// Two-port banked SRAM with word interleaving and round-robin conflict arbitration.
// Reads return one cycle after ack. A port that loses a conflict holds its request. Parity: CLUSTERV_SRAM_PARITY_EN.
module clusterv_tile_sram_banked #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_BANKS  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    t0_req,
  output logic                    t0_ack,
  input  logic                    t0_we,
  input  logic [ADDR_WIDTH-1:0]   t0_addr,
  input  logic [DATA_WIDTH/8-1:0] t0_byte_en,
  input  logic [DATA_WIDTH-1:0]   t0_write_data,
  output logic                    t0_read_valid,
  output logic [DATA_WIDTH-1:0]   t0_read_data,
  input  logic                    t1_req,
  output logic                    t1_ack,
  input  logic                    t1_we,
  input  logic [ADDR_WIDTH-1:0]   t1_addr,
  input  logic [DATA_WIDTH/8-1:0] t1_byte_en,
  input  logic [DATA_WIDTH-1:0]   t1_write_data,
  output logic                    t1_read_valid,
`ifdef CLUSTERV_SRAM_PARITY_EN
  input  logic                    inject_parity_err,
  output logic                    t0_parity_err,
  output logic                    t1_parity_err,
`endif
  output logic [DATA_WIDTH-1:0]   t1_read_data
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LOG2  = $clog2(NUM_BANKS);
  localparam int BW    = (LOG2 > 0) ? LOG2 : 1;
  localparam int ROW_W = ADDR_WIDTH - LOG2;
  localparam int DEPTH = 2 ** ROW_W;

  logic [BW-1:0]    bank0, bank1;
  logic [ROW_W-1:0] row0, row1;

  generate
    if (LOG2 > 0) begin : g_banked
      assign bank0 = t0_addr[LOG2-1:0];
      assign bank1 = t1_addr[LOG2-1:0];
      assign row0  = t0_addr[ADDR_WIDTH-1:LOG2];
      assign row1  = t1_addr[ADDR_WIDTH-1:LOG2];
    end else begin : g_single
      assign bank0 = '0;
      assign bank1 = '0;
      assign row0  = t0_addr;
      assign row1  = t1_addr;
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][DEPTH];

  logic prio;
  logic conflict;
  logic rd_en0, rd_en1;

  // prio names the port that wins the next same-bank conflict
  assign conflict = t0_req && t1_req && (bank0 == bank1);
  assign t0_ack   = reset && t0_req && (!conflict || !prio);
  assign t1_ack   = reset && t1_req && (!conflict ||  prio);
  assign rd_en0   = t0_ack && !t0_we;
  assign rd_en1   = t1_ack && !t1_we;

  always_ff @(posedge clock) begin
    for (int i = 0; i < NB; i++) begin
      if (t0_ack && t0_we && t0_byte_en[i])
        mem[bank0][row0][8*i +: 8] <= t0_write_data[8*i +: 8];
      if (t1_ack && t1_we && t1_byte_en[i])
        mem[bank1][row1][8*i +: 8] <= t1_write_data[8*i +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      prio          <= 1'b0;
      t0_read_valid <= 1'b0;
      t1_read_valid <= 1'b0;
      t0_read_data  <= '0;
      t1_read_data  <= '0;
    end else begin
      if (conflict)
        prio <= ~prio;
      t0_read_valid <= rd_en0;
      t1_read_valid <= rd_en1;
      if (rd_en0)
        t0_read_data <= mem[bank0][row0];
      if (rd_en1)
        t1_read_data <= mem[bank1][row1];
    end
  end

`ifdef CLUSTERV_SRAM_PARITY_EN
  logic [NB-1:0] par [NUM_BANKS][DEPTH];
  logic [NB-1:0] calc0, calc1;
  logic [DATA_WIDTH-1:0] word0, word1;

  assign word0 = mem[bank0][row0];
  assign word1 = mem[bank1][row1];

  always_comb begin
    calc0 = '0;
    calc1 = '0;
    for (int i = 0; i < NB; i++) begin
      calc0[i] = ^word0[8*i +: 8];
      calc1[i] = ^word1[8*i +: 8];
    end
  end

  // even parity per byte; inject flips the stored bit so reads flag it
  always_ff @(posedge clock) begin
    for (int i = 0; i < NB; i++) begin
      if (t0_ack && t0_we && t0_byte_en[i])
        par[bank0][row0][i] <= (^t0_write_data[8*i +: 8]) ^ inject_parity_err;
      if (t1_ack && t1_we && t1_byte_en[i])
        par[bank1][row1][i] <= (^t1_write_data[8*i +: 8]) ^ inject_parity_err;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      t0_parity_err <= 1'b0;
      t1_parity_err <= 1'b0;
    end else begin
      t0_parity_err <= rd_en0 && (|(calc0 ^ par[bank0][row0]));
      t1_parity_err <= rd_en1 && (|(calc1 ^ par[bank1][row1]));
    end
  end
`endif

endmodule

// File: tb/tb_clusterv_tile_sram_banked.sv
// Randomized bench for clusterv_tile_sram_banked against a word-array reference model.
module tb_clusterv_tile_sram_banked;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int NBANK = 4;

  logic clock = 1'b0;
  logic reset;
  logic t0_req, t0_ack, t0_we, t0_read_valid;
  logic t1_req, t1_ack, t1_we, t1_read_valid;
  logic [AW-1:0] t0_addr, t1_addr;
  logic [3:0] t0_byte_en, t1_byte_en;
  logic [DW-1:0] t0_write_data, t1_write_data, t0_read_data, t1_read_data;
`ifdef CLUSTERV_SRAM_PARITY_EN
  logic inject_parity_err, t0_parity_err, t1_parity_err;
`endif

  always #5 clock = ~clock;

  clusterv_tile_sram_banked #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NBANK)) dut (
    .clock(clock), .reset(reset),
    .t0_req(t0_req), .t0_ack(t0_ack), .t0_we(t0_we), .t0_addr(t0_addr),
    .t0_byte_en(t0_byte_en), .t0_write_data(t0_write_data),
    .t0_read_valid(t0_read_valid), .t0_read_data(t0_read_data),
    .t1_req(t1_req), .t1_ack(t1_ack), .t1_we(t1_we), .t1_addr(t1_addr),
    .t1_byte_en(t1_byte_en), .t1_write_data(t1_write_data),
    .t1_read_valid(t1_read_valid),
`ifdef CLUSTERV_SRAM_PARITY_EN
    .inject_parity_err(inject_parity_err),
    .t0_parity_err(t0_parity_err), .t1_parity_err(t1_parity_err),
`endif
    .t1_read_data(t1_read_data)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: flat word memory, per-byte bad-parity flags, and whose turn it is.
  logic [DW-1:0] mmem [2**AW];
  logic [3:0]    mbad [2**AW];
  int            turn;              // 0 or 1: which port wins the next same-bank clash
  logic          xrv0, xrv1, xpe0, xpe1;
  logic [DW-1:0] xrd0, xrd1;
  logic          a0, a1;

  task automatic model_write(input int addr, input logic [3:0] be, input logic [DW-1:0] wd,
                             input logic inj);
    for (int i = 0; i < 4; i++)
      if (be[i]) begin
        mmem[addr][8*i +: 8] = wd[8*i +: 8];
        mbad[addr][i] = inj;
      end
  endtask

  // One clock cycle: check acks and the outputs of the previous cycle, then advance the model.
  task automatic step();
    logic e0, e1, clash, inj;
    logic nrv0, nrv1, npe0, npe1;
    logic [DW-1:0] nrd0, nrd1;
    int ad0, ad1;
    @(negedge clock);
    ad0 = int'(t0_addr);
    ad1 = int'(t1_addr);
    inj = 1'b0;
`ifdef CLUSTERV_SRAM_PARITY_EN
    inj = inject_parity_err;
`endif
    clash = t0_req && t1_req && ((ad0 % NBANK) == (ad1 % NBANK));
    e0 = 1'b0;
    e1 = 1'b0;
    if (reset === 1'b1) begin
      if (clash) begin
        e0 = (turn == 0);
        e1 = (turn == 1);
      end else begin
        e0 = t0_req;
        e1 = t1_req;
      end
    end
    check("ack0", t0_ack, e0);
    check("ack1", t1_ack, e1);
    check("rvalid0", t0_read_valid, xrv0);
    check("rvalid1", t1_read_valid, xrv1);
    check("rdata0", t0_read_data, xrd0);
    check("rdata1", t1_read_data, xrd1);
`ifdef CLUSTERV_SRAM_PARITY_EN
    check("perr0", t0_parity_err, xpe0);
    check("perr1", t1_parity_err, xpe1);
`endif
    a0 = t0_ack;
    a1 = t1_ack;
    nrv0 = e0 && !t0_we;
    nrv1 = e1 && !t1_we;
    nrd0 = xrd0;
    nrd1 = xrd1;
    npe0 = nrv0 && (mbad[ad0] != 4'h0);
    npe1 = nrv1 && (mbad[ad1] != 4'h0);
    if (nrv0) nrd0 = mmem[ad0];
    if (nrv1) nrd1 = mmem[ad1];
    if (reset !== 1'b1) begin
      nrd0 = '0;
      nrd1 = '0;
      turn = 0;
    end else if (clash) begin
      turn = 1 - turn;
    end
    if (e0 && t0_we) model_write(ad0, t0_byte_en, t0_write_data, inj);
    if (e1 && t1_we) model_write(ad1, t1_byte_en, t1_write_data, inj);
    @(posedge clock);
    #1;
    xrv0 = nrv0; xrv1 = nrv1; xrd0 = nrd0; xrd1 = nrd1; xpe0 = npe0; xpe1 = npe1;
  endtask

  task automatic drive0(input logic req, input logic we, input int addr, input logic [3:0] be,
                        input logic [DW-1:0] wd);
    t0_req = req; t0_we = we; t0_addr = AW'(addr); t0_byte_en = be; t0_write_data = wd;
  endtask

  task automatic drive1(input logic req, input logic we, input int addr, input logic [3:0] be,
                        input logic [DW-1:0] wd);
    t1_req = req; t1_we = we; t1_addr = AW'(addr); t1_byte_en = be; t1_write_data = wd;
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mmem[i] = '0;
      mbad[i] = '0;
    end
    turn = 0;
    reset = 1'b0;
`ifdef CLUSTERV_SRAM_PARITY_EN
    inject_parity_err = 1'b0;
`endif
    drive0(1, 0, 0, 4'h0, '0);
    drive1(0, 0, 0, 4'h0, '0);
    @(posedge clock);
    #1;
    xrv0 = 0; xrv1 = 0; xrd0 = '0; xrd1 = '0; xpe0 = 0; xpe1 = 0;
    // reset held with t0 requesting: nothing acked, outputs stay zero
    step();
    step();
    reset = 1'b1;
    drive0(0, 0, 0, 4'h0, '0);

    // preload addresses 0..31 through t1
    for (int a = 0; a < 32; a++) begin
      drive1(1, 1, a, 4'hF, $urandom);
      step();
    end
    drive1(0, 0, 0, 4'h0, '0);

    // full write then single-byte merge, read the following cycle
    drive0(1, 1, 5, 4'hF, 32'hDEADBEEF); step();
    drive0(1, 1, 5, 4'h1, 32'h000000AA); step();
    drive0(1, 0, 5, 4'h0, '0); step();
    check("rmw_valid", t0_read_valid, 1);
    check("rmw_data", t0_read_data, 32'hDEADBEAA);

    // different banks in the same cycle: both granted
    drive0(1, 0, 4, 4'h0, '0);
    drive1(1, 0, 5, 4'h0, '0);
    step();
    check("par_ack", {a0, a1}, 2'b11);
    check("par_data0", t0_read_data, mmem[4]);
    check("par_data1", t1_read_data, mmem[5]);

    // same-bank conflict three cycles running: t0, t1, t0
    drive0(1, 0, 8, 4'h0, '0);
    drive1(1, 0, 8, 4'h0, '0);
    step(); check("conf_c1", {a0, a1}, 2'b10);
    step(); check("conf_c2", {a0, a1}, 2'b01);
    step(); check("conf_c3", {a0, a1}, 2'b10);
    drive0(0, 0, 0, 4'h0, '0);

    // back-to-back t1 reads, one result per cycle
    for (int a = 0; a < 8; a++) begin
      drive1(1, 0, a, 4'h0, '0);
      step();
      check("b2b_valid", t1_read_valid, 1);
      check("b2b_data", t1_read_data, mmem[a]);
    end
    drive1(0, 0, 0, 4'h0, '0);
    step();

    // write before a reset pulse survives it
    drive0(1, 1, 9, 4'hF, 32'h13579BDF); step();
    drive0(1, 0, 9, 4'h0, '0);
    reset = 1'b0; step();
    reset = 1'b1; step();
    check("post_rst_data", t0_read_data, 32'h13579BDF);

`ifdef CLUSTERV_SRAM_PARITY_EN
    inject_parity_err = 1'b1;
    drive0(1, 1, 3, 4'hF, 32'h0F0F1234); step();
    inject_parity_err = 1'b0;
    drive0(1, 0, 3, 4'h0, '0); step();
    check("perr_inj", {t0_read_valid, t0_parity_err}, 2'b11);
    drive0(1, 1, 3, 4'hF, 32'h0F0F1234); step();
    drive0(1, 0, 3, 4'h0, '0); step();
    check("perr_clean", {t0_read_valid, t0_parity_err}, 2'b10);
`endif

    // random traffic over the preloaded window; unacked requests are held
    drive0(0, 0, 0, 4'h0, '0);
    a0 = 1'b0;
    a1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!(t0_req && !a0))
        drive0($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 31),
               4'($urandom), $urandom);
      if (!(t1_req && !a1))
        drive1($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 31),
               4'($urandom), $urandom);
`ifdef CLUSTERV_SRAM_PARITY_EN
      inject_parity_err = ($urandom_range(0, 9) == 0);
`endif
      reset = ($urandom_range(0, 79) != 0);
      step();
    end
    reset = 1'b1;
    drive0(0, 0, 0, 4'h0, '0);
    drive1(0, 0, 0, 4'h0, '0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clusterv_tile_sram_banked.md
Name: clusterv_tile_sram_banked

Overview:
Parametrised, banked successor to the tile single-port SRAM wrapper. Serves two independent requester ports (t0: core, t1: DMA/debug) over NUM_BANKS word-interleaved byte-enabled SRAM banks. Grants both ports in the same cycle when they hit different banks, and arbitrates round-robin on same-bank conflicts. Sits between the tile interconnect and the tile-local memory macros.

Parameters:
DATA_WIDTH, 32, data bits per word; multiple of 8.
ADDR_WIDTH, 10, word-address bits per port; total depth is 2**ADDR_WIDTH words.
NUM_BANKS, 4, bank count; power of two, 1..16. Bank depth is 2**ADDR_WIDTH/NUM_BANKS.

Ports:
clock  input  1  sole clock, rising edge.
reset  input  1  synchronous, active-low reset.
tN_req  input  1  request valid (N=0,1); held until the ack cycle.
tN_ack  output  1  request accepted this cycle (combinational from req and the arbiter).
tN_we  input  1  1 = write, 0 = read.
tN_addr  input  ADDR_WIDTH  word address.
tN_byte_en  input  DATA_WIDTH/8  write byte lanes; ignored on reads.
tN_write_data  input  DATA_WIDTH  write data.
tN_read_valid  output  1  one-cycle pulse; read data is valid.
tN_read_data  output  DATA_WIDTH  read data; holds its last value between reads.

Behaviour:
- Bank select is addr[log2(NUM_BANKS)-1:0]. Row is the remaining upper bits. With NUM_BANKS=1 there are no bank bits.
- Each bank is a 1RW synchronous array: one access per cycle, write-first not required.
- Arbitration, same cycle:
  - Only one port requesting: it is acked.
  - Both requesting, different banks: both acked.
  - Both requesting, same bank: the port named by the prio bit is acked. The other gets ack=0 and must hold its request.
- prio (reset 0 = t0) flips to the loser after every conflict cycle. It is unchanged on non-conflict cycles.
- While reset=0: ack=0, no array access.
- Write on ack: bytes with byte_en=1 are updated at that clock edge. Other bytes are retained. byte_en=0 is a legal no-op write that is still acked.
- Read on ack in cycle N:
  - tN_read_valid=1 and tN_read_data=mem[addr] in cycle N+1.
  - Latency is fixed at 1 cycle. Back-to-back reads give one result per cycle.
- Read after write, same address:
  - Write acked in cycle N, read acked in cycle N+1 or later: the read returns the new data.
  - Both ports on the same address always conflict, so they are serialised in grant order.
- Reset values: tN_read_valid=0, tN_read_data=0, prio=0. Array contents are not cleared.
- Reset asserted mid-operation: a pending read_valid for cycle N+1 is suppressed. A write acked before reset stands.

Optional Feature:
CLUSTERV_SRAM_PARITY_EN
- Defined:
  - Each byte stores an even-parity bit, written together with its byte.
  - Added outputs tN_parity_err (1 bit, reset 0) are asserted with read_valid when any byte's stored parity mismatches.
  - Added input inject_parity_err (1 bit) inverts the stored parity on writes while high, for test.
- Not defined: no parity storage and no extra ports; behaviour is otherwise identical.

Test Plan:
- Reset with reset=0 for 2 cycles while t0_req=1 -> t0_ack=0, read_valid=0, read_data=0 throughout.
- t0 writes 0xDEADBEEF to addr 5 with byte_en=4'b1111, then writes 0x000000AA with byte_en=4'b0001 -> t0 read of addr 5 in the following cycle gives 0xDEADBEAA, with read_valid exactly one cycle after ack.
- t0 reads addr 4 (bank 0) while t1 reads addr 5 (bank 1) in the same cycle -> both acked; both read_valid next cycle with their own data.
- t0 and t1 both request addr 8 (bank 0) for 3 consecutive cycles -> ack order t0, t1, t0; the loser's ack=0 each cycle; prio toggles each conflict.
- Back-to-back t1 reads of addrs 0..7 over 8 cycles -> 8 consecutive read_valid pulses with the data written earlier, no bubbles.
- With CLUSTERV_SRAM_PARITY_EN: write addr 3 with inject_parity_err=1, then read it -> t0_parity_err=1 together with read_valid. Rewrite addr 3 with inject_parity_err=0 and read it -> parity_err=0.
